// File: rtl/jtag_host.sv
// JTAG host: sequences TCK/TMS/TDI for TAP reset, IR and DR scans issued from the CLK domain
// and returns the TDO bits captured while shifting.
module jtag_host #(
  parameter int REGISTER_SIZE = 32,
  parameter int IR_SIZE       = 4,
  parameter int CLK_DIV       = 1,
  parameter int LEN_W         = $clog2(REGISTER_SIZE)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [LEN_W-1:0]         CMD_LEN,
  input  logic [REGISTER_SIZE-1:0] CMD_DATA,
  output logic                     RSP_VALID,
  output logic [REGISTER_SIZE-1:0] RSP_DATA,
  output logic                     TCK,
  output logic                     TMS,
  output logic                     TDI,
  input  logic                     TDO
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     tck_q, tck_d;
  logic                     tms_q, tms_d;
  logic                     tdi_q, tdi_d;
  logic                     is_ir_q, is_ir_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [REGISTER_SIZE-1:0] data_q, data_d;
  logic [REGISTER_SIZE-1:0] cap_q, cap_d;
  logic                     cmd_rst_q, cmd_rst_d;
  logic [REGISTER_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                     last_phase;

  // TMS value presented for TCK cycle c of state st
  function automatic logic tms_of(input logic [2:0] st, input logic [LEN_W-1:0] c,
                                  input logic ir, input logic [LEN_W-1:0] n1);
    logic v;
    v = 1'b0;
    case (st)
      S_RST:   v = (c != LEN_W'(5));
      S_HDR:   v = ir ? (c < LEN_W'(2)) : (c == '0);
      S_SHIFT: v = (c == n1);
      S_TAIL:  v = (c == '0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign last_phase = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    is_ir_d    = is_ir_q;
    len_d      = len_q;
    data_d     = data_q;
    cap_d      = cap_q;
    cmd_rst_d  = cmd_rst_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (CMD_VALID) begin
          cnt_d  = '0;
          div_d  = '0;
          data_d = CMD_DATA;
          cap_d  = '0;
          tms_d  = 1'b1;  // first TCK of every sequence carries TMS=1
          case (CMD_TYPE)
            2'd1: begin
              state_d = S_HDR; is_ir_d = 1'b1; len_d = LEN_W'(IR_SIZE - 1); cmd_rst_d = 1'b0;
            end
            2'd2: begin
              state_d = S_HDR; is_ir_d = 1'b0; len_d = CMD_LEN; cmd_rst_d = 1'b0;
            end
            default: begin
              state_d = S_RST; cmd_rst_d = 1'b1;
            end
          endcase
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        div_d = last_phase ? '0 : div_q + DIV_W'(1);
        if (last_phase && !tck_q) begin
          tck_d = 1'b1;
          if (state_q == S_SHIFT) cap_d[cnt_q] = TDO;
        end else if (last_phase) begin
          // falling edge: step to the next TCK cycle and present its TMS/TDI
          tck_d = 1'b0;
          cnt_d = cnt_q + LEN_W'(1);
          case (state_q)
            S_RST: if (cnt_q == LEN_W'(5)) begin
              state_d = cmd_rst_q ? S_DONE : S_IDLE;
              cnt_d   = '0;
            end
            S_HDR: if (cnt_q == (is_ir_q ? LEN_W'(3) : LEN_W'(2))) begin
              state_d = S_SHIFT;
              cnt_d   = '0;
            end
            S_SHIFT: if (cnt_q == len_q) begin
              state_d = S_TAIL;
              cnt_d   = '0;
            end
            S_TAIL: if (cnt_q == LEN_W'(1)) begin
              state_d    = S_DONE;
              cnt_d      = '0;
              rsp_data_d = cap_q;
            end
            default: state_d = S_IDLE;
          endcase
          tms_d = tms_of(state_d, cnt_d, is_ir_q, len_q);
          tdi_d = (state_d == S_SHIFT) ? data_q[cnt_d] : 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      is_ir_q    <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      cmd_rst_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      is_ir_q    <= is_ir_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      cmd_rst_q  <= cmd_rst_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_DONE);
  assign RSP_DATA  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: directed vector table, randomized scans against a pin-level TAP model,
// a CLK_DIV=3 timing instance and a mid-scan reset sequence.
module tb_jtag_host;
  localparam int IRS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // CLK_DIV=1 instance
  logic        rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0]  cmd_type = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rdy, rsp_v, tck, tms, tdi, tdo;
  logic [31:0] rsp_d;

  // CLK_DIV=3 instance
  logic        rst3 = 1'b1, cmd_valid3 = 1'b0;
  logic [1:0]  cmd_type3 = '0;
  logic [4:0]  cmd_len3 = '0;
  logic [31:0] cmd_data3 = '0;
  logic        rdy3, rsp_v3, tck3, tms3, tdi3;
  logic [31:0] rsp_d3;

  jtag_host #(.REGISTER_SIZE(32), .IR_SIZE(IRS), .CLK_DIV(1)) u_dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(rdy), .CMD_TYPE(cmd_type),
    .CMD_LEN(cmd_len), .CMD_DATA(cmd_data), .RSP_VALID(rsp_v), .RSP_DATA(rsp_d),
    .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo));

  jtag_host #(.REGISTER_SIZE(32), .IR_SIZE(IRS), .CLK_DIV(3)) u_dut3 (
    .CLK(clk), .RST(rst3), .CMD_VALID(cmd_valid3), .CMD_READY(rdy3), .CMD_TYPE(cmd_type3),
    .CMD_LEN(cmd_len3), .CMD_DATA(cmd_data3), .RSP_VALID(rsp_v3), .RSP_DATA(rsp_d3),
    .TCK(tck3), .TMS(tms3), .TDI(tdi3), .TDO(1'b0));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // TAP-side model: log TMS/TDI at every TCK rise; TDO is either TDI looped back or
  // a pattern bit indexed by the rising-edge number since the command was issued
  bit        tms_log[$], tdi_log[$];
  int        edge_cnt = 0, base = 0;
  bit        loop = 1'b0;
  bit [63:0] pat = '0;
  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    edge_cnt++;
  end
  assign tdo = loop ? tdi : pat[6'(edge_cnt - base)];

  int          rsp_cnt = 0;
  logic [31:0] rsp_seen = '0;
  always @(negedge clk) if (rsp_v) begin rsp_cnt++; rsp_seen = rsp_d; end

  // CLK_DIV=3 observers: TCK run lengths in CLK cycles, edges and responses
  int edge3 = 0, rsp3 = 0, hi_bad = 0, lo_bad = 0, hi_runs = 0, lo_runs = 0, run3 = 0;
  bit prev3 = 1'b0, after_fall = 1'b0;
  always @(posedge tck3) edge3++;
  always @(negedge clk) begin
    if (rsp_v3) rsp3++;
    if (tck3 !== prev3) begin
      if (prev3) begin
        hi_runs++; if (run3 != 3) hi_bad++;
        after_fall = 1'b1;
      end else if (after_fall) begin
        lo_runs++; if (run3 != 3) lo_bad++;
      end
      run3 = 1; prev3 = tck3;
    end else run3++;
    if (rst3 || rdy3) after_fall = 1'b0;
  end

  logic [31:0] model_rsp = '0;

  task automatic wait_ready(input int lim, output bit ok);
    ok = rdy;
    for (int i = 0; i < lim && !ok; i++) begin @(negedge clk); ok = rdy; end
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [4:0] ln, input logic [31:0] d,
                         input bit lp, input bit [63:0] pt, input string tag,
                         output logic [63:0] a_tms, output int a_edges, output logic [31:0] a_rsp);
    int hdr, n, tot, st, rc;
    bit ok, scan;
    logic [63:0] e_tms, e_tdi, a_tdi;
    logic [31:0] e_rsp;
    scan  = (t == 2'd1) || (t == 2'd2);
    hdr   = (t == 2'd1) ? 4 : 3;
    n     = (t == 2'd1) ? IRS : int'(ln) + 1;
    e_tms = '0; e_tdi = '0; e_rsp = '0;
    if (scan) begin
      for (int k = 0; k < hdr; k++) e_tms[k] = (t == 2'd1) ? (k < 2) : (k == 0);
      e_tms[hdr+n-1] = 1'b1;
      e_tms[hdr+n]   = 1'b1;
      tot = hdr + n + 2;
      for (int i = 0; i < n; i++) begin
        e_tdi[i] = d[i];
        e_rsp[i] = lp ? d[i] : pt[hdr+i];
      end
    end else begin
      e_tms = 64'h1F;
      tot   = 6;
      e_rsp = model_rsp;
    end
    wait_ready(500, ok);
    chk({tag, " ready before"}, 64'(ok), 64'd1);
    loop = lp; pat = pt;
    @(negedge clk);
    base = edge_cnt; st = edge_cnt; rc = rsp_cnt;
    cmd_type = t; cmd_len = ln; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, " ready drop"}, 64'(rdy), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); ok = (rsp_cnt != rc); end
    chk({tag, " rsp seen"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    a_edges = edge_cnt - st;
    a_tms = '0;
    for (int i = 0; i < a_edges && i < 64; i++) a_tms[i] = tms_log[st+i];
    a_rsp = rsp_seen;
    chk({tag, " tck edges"}, 64'(a_edges), 64'(tot));
    chk({tag, " tms seq"}, a_tms, e_tms);
    chk({tag, " rsp pulses"}, 64'(rsp_cnt - rc), 64'd1);
    chk({tag, " rsp data"}, 64'(a_rsp), 64'(e_rsp));
    chk({tag, " ready after"}, 64'(rdy), 64'd1);
    if (scan) begin
      a_tdi = '0;
      for (int i = 0; i < n + 2; i++)
        if (st + hdr + i < tdi_log.size()) a_tdi[i] = tdi_log[st+hdr+i];
      chk({tag, " tdi seq"}, a_tdi, e_tdi);
    end
    model_rsp = e_rsp;
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  len;
    logic [31:0] data;
    bit          lp;
    bit [63:0]   pt;
    logic [63:0] exp_tms;
    int          exp_edges;
    logic [31:0] exp_rsp;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [63:0] a_tms;
    int          a_edges, st, rc;
    logic [31:0] a_rsp;
    bit          ok;
    int          bad_rdy;

    tbl[0] = '{2'd1, 5'd0,  32'h8,        1'b1, 64'h0,              64'h183,          10, 32'h8};
    tbl[1] = '{2'd2, 5'd31, 32'h89abcdef, 1'b1, 64'h0,              64'hC_0000_0001,  37, 32'h89abcdef};
    tbl[2] = '{2'd2, 5'd0,  32'h1,        1'b0, '1,                 64'h19,           6,  32'h1};
    tbl[3] = '{2'd3, 5'd7,  32'hffff_ffff, 1'b0, 64'h0,             64'h1F,           6,  32'h1};
    tbl[4] = '{2'd1, 5'd0,  32'h0,        1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h183,     10, 32'hA};

    // reset values while RST is held
    repeat (3) @(negedge clk);
    chk("rst tck", 64'(tck), 64'd0);
    chk("rst tms", 64'(tms), 64'd1);
    chk("rst tdi", 64'(tdi), 64'd0);
    chk("rst ready", 64'(rdy), 64'd0);
    chk("rst rsp_valid", 64'(rsp_v), 64'd0);
    chk("rst rsp_data", 64'(rsp_d), 64'd0);

    // automatic reset sequence after release
    rst = 1'b0; rst3 = 1'b0;
    wait_ready(200, ok);
    chk("boot ready", 64'(ok), 64'd1);
    a_tms = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) a_tms[i] = tms_log[i];
    chk("boot edges", 64'(edge_cnt), 64'd6);
    chk("boot tms seq", a_tms, 64'h1F);
    chk("boot no rsp", 64'(rsp_cnt), 64'd0);

    for (int v = 0; v < 5; v++) begin
      run_cmd(tbl[v].t, tbl[v].len, tbl[v].data, tbl[v].lp, tbl[v].pt,
              $sformatf("vec%0d", v), a_tms, a_edges, a_rsp);
      chk($sformatf("vec%0d table tms", v), a_tms, tbl[v].exp_tms);
      chk($sformatf("vec%0d table edges", v), 64'(a_edges), 64'(tbl[v].exp_edges));
      chk($sformatf("vec%0d table rsp", v), 64'(a_rsp), 64'(tbl[v].exp_rsp));
    end

    for (int r = 0; r < 25; r++)
      run_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
              bit'($urandom_range(0, 1)), {$urandom, $urandom},
              $sformatf("rnd%0d", r), a_tms, a_edges, a_rsp);

    // CLK_DIV=3: phase lengths, and CMD_VALID held during the scan is ignored
    ok = rdy3;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = rdy3; end
    chk("div3 ready", 64'(ok), 64'd1);
    st = edge3; rc = rsp3;
    cmd_type3 = 2'd1; cmd_data3 = 32'h5; cmd_valid3 = 1'b1;
    @(negedge clk);
    bad_rdy = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (rdy3) bad_rdy++; end
    cmd_valid3 = 1'b0;
    chk("div3 ready low while busy", 64'(bad_rdy), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); ok = (rsp3 != rc); end
    chk("div3 rsp seen", 64'(ok), 64'd1);
    repeat (60) @(negedge clk);
    chk("div3 edges", 64'(edge3 - st), 64'd10);
    chk("div3 rsp pulses", 64'(rsp3 - rc), 64'd1);
    chk("div3 high runs bad", 64'(hi_bad), 64'd0);
    chk("div3 low runs bad", 64'(lo_bad), 64'd0);
    chk("div3 high runs seen", 64'(hi_runs >= 16), 64'd1);
    chk("div3 low runs seen", 64'(lo_runs >= 14), 64'd1);

    // RST in the middle of a long DR shift
    wait_ready(200, ok);
    loop = 1'b1;
    @(negedge clk);
    st = edge_cnt; base = edge_cnt;
    cmd_type = 2'd2; cmd_len = 5'd31; cmd_data = 32'hdead_beef; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = (edge_cnt - st >= 14); end
    chk("midrst reached bit 10", 64'(ok), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst tck", 64'(tck), 64'd0);
    chk("midrst tms", 64'(tms), 64'd1);
    @(negedge clk);
    chk("midrst ready", 64'(rdy), 64'd0);
    chk("midrst rsp_data", 64'(rsp_d), 64'd0);
    rst = 1'b0;
    st = edge_cnt; rc = rsp_cnt;
    wait_ready(200, ok);
    chk("midrst ready after seq", 64'(ok), 64'd1);
    a_tms = '0;
    for (int i = 0; i < edge_cnt - st && i < 64; i++) a_tms[i] = tms_log[st+i];
    chk("midrst edges", 64'(edge_cnt - st), 64'd6);
    chk("midrst tms seq", a_tms, 64'h1F);
    chk("midrst no rsp", 64'(rsp_cnt - rc), 64'd0);
    model_rsp = '0;

    run_cmd(2'd2, 5'd15, 32'h0000_c3a5, 1'b1, 64'h0, "post", a_tms, a_edges, a_rsp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
